dct_sequencer: RTL and testbench

DCT_SEQUENCER -- requirements
Module: dct_sequencer

---
 rtl/dct_pkg.sv | 19 +
 rtl/dct_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_dct_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared definitions for the DCT job sequencer: peripheral register map and FSM states.
package dct_pkg;

    localparam logic [7:0] ADDR_START = 8'd0;
    localparam logic [7:0] ADDR_DATA  = 8'd1;
    localparam logic [7:0] ADDR_SETQ  = 8'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETQ,
        S_START,
        S_LD_RD,
        S_LD_WR,
        S_RS_RD,
        S_RS_WR,
        S_DONE
    } dct_state_t;

endpackage

// File: rtl/dct_sequencer.sv
// Streams N samples from memory into the DCT peripheral and copies the N results back.
// Optional RS_RD stall watchdog enabled by defining DCT_SEQ_TIMEOUT_EN.
module dct_sequencer
    import dct_pkg::*;
#(
    parameter int MAX_SIZE       = 128,
    parameter int NBITS          = 16,
    parameter int AW             = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       size,
    input  logic [NBITS-1:0] qm,
    input  logic [AW-1:0]    src_base,
    input  logic [AW-1:0]    dst_base,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_read,
    output logic             mem_write,
    output logic [NBITS-1:0] mem_wdata,
    input  logic [NBITS-1:0] mem_rdata,
    output logic [7:0]       dct_address,
    output logic             dct_read,
    output logic             dct_write,
    output logic [NBITS-1:0] dct_writedata,
    input  logic [NBITS-1:0] dct_readdata,
    input  logic             dct_done
);

    dct_state_t       state;
    logic [7:0]       n_q;
    logic [7:0]       k;
    logic [AW-1:0]    src_q;
    logic [AW-1:0]    dst_q;
    logic [NBITS-1:0] wdata_q;
    logic             size_bad_c;
    logic             k_last_c;

`ifdef DCT_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] stall_cnt;
`endif

    assign size_bad_c = (size < 8'd2) || (int'(size) > MAX_SIZE);
    assign k_last_c   = (k == n_q - 8'd1);

    // Memory read data lands in LD_WR, so the sample is forwarded straight to the peripheral.
    assign dct_writedata = (state == S_LD_WR) ? mem_rdata : wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            n_q         <= '0;
            k           <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            wdata_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_addr    <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_wdata   <= '0;
            dct_address <= '0;
            dct_read    <= 1'b0;
            dct_write   <= 1'b0;
`ifdef DCT_SEQ_TIMEOUT_EN
            stall_cnt   <= '0;
`endif
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            dct_read  <= 1'b0;
            dct_write <= 1'b0;
            done      <= 1'b0;

            // Outputs are set on the edge entering the state they belong to.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_q   <= size;
                        src_q <= src_base;
                        dst_q <= dst_base;
                        k     <= '0;
                        busy  <= 1'b1;
                        if (size_bad_c) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err         <= 1'b0;
                            dct_write   <= 1'b1;
                            dct_address <= ADDR_SETQ;
                            wdata_q     <= qm;
                            state       <= S_SETQ;
                        end
                    end
                end
                S_SETQ: begin
                    dct_write   <= 1'b1;
                    dct_address <= ADDR_START;
                    wdata_q     <= NBITS'(n_q);
                    state       <= S_START;
                end
                S_START: begin
                    mem_read <= 1'b1;
                    mem_addr <= src_q + AW'(k);
                    state    <= S_LD_RD;
                end
                S_LD_RD: begin
                    dct_write   <= 1'b1;
                    dct_address <= ADDR_DATA;
                    state       <= S_LD_WR;
                end
                S_LD_WR: begin
                    if (k_last_c) begin
                        k           <= '0;
                        dct_read    <= 1'b1;
                        dct_address <= 8'd0;
                        state       <= S_RS_RD;
                    end else begin
                        k        <= k + 8'd1;
                        mem_read <= 1'b1;
                        mem_addr <= src_q + AW'(k + 8'd1);
                        state    <= S_LD_RD;
                    end
                end
                S_RS_RD: begin
                    if (dct_done) begin
                        mem_write <= 1'b1;
                        mem_addr  <= dst_q + AW'(k);
                        mem_wdata <= dct_readdata;
                        state     <= S_RS_WR;
`ifdef DCT_SEQ_TIMEOUT_EN
                        stall_cnt <= '0;
`endif
                    end else begin
`ifdef DCT_SEQ_TIMEOUT_EN
                        if (stall_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            stall_cnt <= '0;
                            err       <= 1'b1;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            stall_cnt <= stall_cnt + TW'(1);
                            dct_read  <= 1'b1;
                        end
`else
                        dct_read <= 1'b1;
`endif
                    end
                end
                S_RS_WR: begin
                    if (k_last_c) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        k           <= k + 8'd1;
                        dct_read    <= 1'b1;
                        dct_address <= k + 8'd1;
                        state       <= S_RS_RD;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dct_sequencer.sv
// Randomized self-checking bench for dct_sequencer with memory and DCT peripheral models.
module tb_dct_sequencer;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [7:0]  size;
    logic [15:0] qm, src_base, dst_base;
    logic        busy, done, err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic [7:0]  dct_address;
    logic        dct_read, dct_write, dct_done;
    logic [15:0] dct_writedata, dct_readdata;

    dct_sequencer #(.MAX_SIZE(128), .NBITS(16), .AW(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .size(size), .qm(qm),
        .src_base(src_base), .dst_base(dst_base), .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dct_address(dct_address), .dct_read(dct_read), .dct_write(dct_write),
        .dct_writedata(dct_writedata), .dct_readdata(dct_readdata), .dct_done(dct_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit last_err = 1'b0;

    logic [15:0] mem [0:65535];
    logic [15:0] p_data [0:255];
    logic [15:0] p_qm;
    int          p_cnt = 0;
    int          stall_len = 0;
    int          stall_ctr = 0;
    int          strobe_cnt = 0;
    logic [23:0] dct_wr_q [$];
    logic [31:0] mem_wr_q [$];
    logic [15:0] mem_rd_q [$];
    logic [7:0]  rs_rd_q [$];

    // Peripheral "transform": any deterministic function of the loaded sample, index and qm.
    function automatic logic [15:0] coef(input logic [15:0] s, input int idx, input logic [15:0] q);
        return (s ^ 16'hA5A5) + 16'(idx * 7) + q;
    endfunction

    always_comb dct_done = (stall_ctr >= stall_len);
    always_comb dct_readdata = coef(p_data[dct_address], int'(dct_address), p_qm);

    always @(posedge clk) begin
        if (mem_read) begin
            mem_rdata <= mem[mem_addr];
            mem_rd_q.push_back(mem_addr);
        end
        if (mem_write) mem_wr_q.push_back({mem_addr, mem_wdata});
        if (dct_write) begin
            dct_wr_q.push_back({dct_address, dct_writedata});
            if (dct_address == 8'd2) p_qm <= dct_writedata;
            else if (dct_address == 8'd0) p_cnt <= 0;
            else if (dct_address == 8'd1 && p_cnt < 256) begin
                p_data[p_cnt] <= dct_writedata;
                p_cnt <= p_cnt + 1;
            end
        end
        if (dct_read && dct_done) rs_rd_q.push_back(dct_address);
        stall_ctr  <= (dct_read && !dct_done) ? stall_ctr + 1 : 0;
        strobe_cnt <= strobe_cnt + int'(mem_read) + int'(mem_write) + int'(dct_read) + int'(dct_write);
    end

    int          mon_excl_viol = 0, mon_stab_viol = 0, mon_stall_obs = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_addr = 8'd0;
    always @(negedge clk) begin
        if (int'(mem_read) + int'(mem_write) + int'(dct_read) + int'(dct_write) > 1) mon_excl_viol++;
        if (prev_stall && dct_read) begin
            mon_stall_obs++;
            if (dct_address !== prev_addr) mon_stab_viol++;
        end
        prev_stall = dct_read && !dct_done;
        prev_addr  = dct_address;
    end

    task automatic run_job(input logic [7:0] n, input int kind, input int stall, input int poke,
                           input logic [15:0] q, input logic [15:0] src, input logic [15:0] dst,
                           input logic [15:0] s [$], input string name);
        int dw0, mw0, mr0, rr0, sc0, cyc, exp_lat, busy_low, lim, nn, exp_cnt;
        bit exp_err;
        logic [23:0] exp_dw [$];
        nn = int'(n);
        exp_err = (kind != 0);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        vectors++;
        if (err !== last_err) begin
            miscompares++;
            $display("FAIL %s err_hold: got %b want %b", name, err, last_err);
        end
        if (kind != 1) for (int i = 0; i < nn; i++) mem[src + 16'(i)] = s[i];
        dw0 = dct_wr_q.size(); mw0 = mem_wr_q.size(); mr0 = mem_rd_q.size();
        rr0 = rs_rd_q.size(); sc0 = strobe_cnt;
        stall_len = stall;
        start = 1'b1; size = n; qm = q; src_base = src; dst_base = dst;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; size = 8'($urandom); qm = 16'($urandom);
        src_base = 16'($urandom); dst_base = 16'($urandom);
        exp_lat = (kind == 1) ? 1 : (kind == 2) ? 2 * nn + 3 + TO : 4 * nn + 3 + nn * stall;
        lim = exp_lat + 64;
        cyc = 1; busy_low = 0;
        while (done !== 1'b1 && cyc < lim) begin
            if (busy !== 1'b1) busy_low++;
            if (poke > 0 && cyc == poke) begin start = 1'b1; size = n + 8'd3; end
            if (poke > 0 && cyc == poke + 2) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        vectors++;
        if (done !== 1'b1 || cyc != exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d (done=%b) want %0d", name, cyc, done, exp_lat);
        end
        vectors++;
        if (err !== exp_err) begin
            miscompares++;
            $display("FAIL %s err: got %b want %b", name, err, exp_err);
        end
        vectors++;
        if (busy_low != 0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy: low cycles %0d, busy at done %b, want 0 and 1", name, busy_low, busy);
        end
        if (kind != 1) begin
            exp_dw.push_back({8'd2, q});
            exp_dw.push_back({8'd0, 8'd0, n});
            for (int i = 0; i < nn; i++) exp_dw.push_back({8'd1, s[i]});
        end
        vectors++;
        if (dct_wr_q.size() - dw0 != exp_dw.size()) begin
            miscompares++;
            $display("FAIL %s dct_write_count: got %0d want %0d", name, dct_wr_q.size() - dw0, exp_dw.size());
        end else begin
            for (int i = 0; i < exp_dw.size(); i++) begin
                vectors++;
                if (dct_wr_q[dw0 + i] !== exp_dw[i]) begin
                    miscompares++;
                    $display("FAIL %s dct_write[%0d]: got %h want %h", name, i, dct_wr_q[dw0 + i], exp_dw[i]);
                end
            end
        end
        exp_cnt = (kind == 1) ? 0 : nn;
        vectors++;
        if (mem_rd_q.size() - mr0 != exp_cnt) begin
            miscompares++;
            $display("FAIL %s mem_read_count: got %0d want %0d", name, mem_rd_q.size() - mr0, exp_cnt);
        end else begin
            for (int i = 0; i < exp_cnt; i++) begin
                vectors++;
                if (mem_rd_q[mr0 + i] !== src + 16'(i)) begin
                    miscompares++;
                    $display("FAIL %s mem_read_addr[%0d]: got %h want %h", name, i, mem_rd_q[mr0 + i], src + 16'(i));
                end
            end
        end
        exp_cnt = (kind == 0) ? nn : 0;
        vectors++;
        if (mem_wr_q.size() - mw0 != exp_cnt || rs_rd_q.size() - rr0 != exp_cnt) begin
            miscompares++;
            $display("FAIL %s result_count: writes %0d reads %0d want %0d", name,
                     mem_wr_q.size() - mw0, rs_rd_q.size() - rr0, exp_cnt);
        end else begin
            for (int i = 0; i < exp_cnt; i++) begin
                vectors++;
                if (mem_wr_q[mw0 + i] !== {dst + 16'(i), coef(s[i], i, q)} || rs_rd_q[rr0 + i] !== 8'(i)) begin
                    miscompares++;
                    $display("FAIL %s result[%0d]: got %h rd %0d want %h rd %0d", name, i, mem_wr_q[mw0 + i],
                             rs_rd_q[rr0 + i], {dst + 16'(i), coef(s[i], i, q)}, i);
                end
            end
        end
        if (kind == 1) begin
            vectors++;
            if (strobe_cnt - sc0 != 0) begin
                miscompares++;
                $display("FAIL %s strobes: got %0d want 0", name, strobe_cnt - sc0);
            end
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== exp_err) begin
            miscompares++;
            $display("FAIL %s after_done: done %b busy %b err %b want 0 0 %b", name, done, busy, err, exp_err);
        end
        last_err = exp_err;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; size = '0; qm = '0; src_base = '0; dst_base = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, err, mem_read, mem_write, dct_read, dct_write, mem_addr, mem_wdata,
             dct_address, dct_writedata} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy %b done %b err %b strobes %b%b%b%b want all zero",
                     busy, done, err, mem_read, mem_write, dct_read, dct_write);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy %b done %b want 0 0", busy, done);
        end
        last_err = 1'b0;
    endtask

    task automatic test_nominal();
        logic [15:0] s [$];
        s = '{16'd100, 16'd200, 16'd300, 16'd400};
        run_job(8'd4, 0, 0, 0, 16'd1, 16'h0010, 16'h0080, s, "nominal");
    endtask

    task automatic test_stalls();
        logic [15:0] s [$];
        for (int i = 0; i < 3; i++) s.push_back(16'($urandom));
        run_job(8'd3, 0, 5, 0, 16'($urandom), 16'h0400, 16'h0500, s, "stalls");
    endtask

    task automatic test_bad_size();
        logic [15:0] s [$];
        run_job(8'd1, 1, 0, 0, 16'd3, 16'h0010, 16'h0080, s, "size_1");
        run_job(8'd200, 1, 0, 0, 16'd3, 16'h0010, 16'h0080, s, "size_200");
        run_job(8'd0, 1, 0, 0, 16'd3, 16'h0010, 16'h0080, s, "size_0");
        run_job(8'd129, 1, 0, 0, 16'd3, 16'h0010, 16'h0080, s, "size_129");
    endtask

    task automatic test_mid_reset();
        logic [15:0] s [$];
        int cnt, cyc;
        for (int i = 0; i < 5; i++) mem[16'h0200 + 16'(i)] = 16'($urandom);
        start = 1'b1; size = 8'd5; qm = 16'd7; src_base = 16'h0200; dst_base = 16'h0300;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; cnt = 0;
        while (cyc < 40) begin
            if (dct_write === 1'b1 && dct_address == 8'd1) cnt++;
            if (cnt == 3) break;
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cnt != 3 || cyc != 8) begin
            miscompares++;
            $display("FAIL ld_wr_k2_position: got cycle %0d writes %0d want 8 3", cyc, cnt);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({busy, done, err, mem_read, mem_write, dct_read, dct_write, mem_addr, mem_wdata,
             dct_address, dct_writedata} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: busy %b strobes %b%b%b%b addr %h dctaddr %h want zero",
                     busy, mem_read, mem_write, dct_read, dct_write, mem_addr, dct_address);
        end
        last_err = 1'b0;
        for (int i = 0; i < 2; i++) s.push_back(16'($urandom));
        run_job(8'd2, 0, 0, 0, 16'($urandom), 16'h0600, 16'h0700, s, "after_reset");
    endtask

    task automatic test_start_while_busy();
        logic [15:0] s [$];
        for (int i = 0; i < 4; i++) s.push_back(16'($urandom));
        run_job(8'd4, 0, 0, 6, 16'($urandom), 16'h0800, 16'h0900, s, "start_while_busy");
    endtask

    task automatic test_random();
        logic [15:0] s [$];
        logic [15:0] src, dst;
        logic [7:0] n;
        for (int j = 0; j < 7; j++) begin
            n = (j == 6) ? 8'd128 : 8'($urandom_range(2, 24));
            s.delete();
            for (int i = 0; i < int'(n); i++) s.push_back(16'($urandom));
            src = (j == 0) ? 16'hFFFE : 16'($urandom);
            dst = (j == 0) ? 16'hFFFD : 16'($urandom);
            run_job(n, 0, (j == 6) ? 0 : $urandom_range(0, 3), 0, 16'($urandom), src, dst, s,
                    (j == 6) ? "max_size" : "random");
        end
        s = '{16'h1234, 16'hBEEF};
        run_job(8'd2, 0, 1, 0, 16'hFFFF, 16'h0020, 16'h0030, s, "min_size");
    endtask

`ifdef DCT_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        logic [15:0] s [$];
        for (int i = 0; i < 3; i++) s.push_back(16'($urandom));
        run_job(8'd3, 2, 1000000, 0, 16'd2, 16'h0A00, 16'h0B00, s, "timeout");
        stall_len = 0;
    endtask
`else
    task automatic test_no_timeout();
        int seen_done;
        for (int i = 0; i < 3; i++) mem[16'h0A00 + 16'(i)] = 16'($urandom);
        stall_len = 1000000;
        start = 1'b1; size = 8'd3; qm = 16'd2; src_base = 16'h0A00; dst_base = 16'h0B00;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 2 * 3 + 3 + 100; c++) begin
            if (done === 1'b1) seen_done++;
            @(negedge clk);
        end
        vectors++;
        if (seen_done != 0 || busy !== 1'b1 || dct_read !== 1'b1 || dct_address !== 8'd0) begin
            miscompares++;
            $display("FAIL no_timeout_wait: done seen %0d busy %b dct_read %b addr %0d want 0 1 1 0",
                     seen_done, busy, dct_read, dct_address);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        stall_len = 0;
        last_err = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_protocol();
        vectors++;
        if (mon_excl_viol != 0) begin
            miscompares++;
            $display("FAIL strobe_exclusive: got %0d violations want 0", mon_excl_viol);
        end
        vectors++;
        if (mon_stab_viol != 0) begin
            miscompares++;
            $display("FAIL read_addr_stable: got %0d violations want 0", mon_stab_viol);
        end
        vectors++;
        if (mon_stall_obs < 15) begin
            miscompares++;
            $display("FAIL stall_hold_seen: got %0d held cycles want at least 15", mon_stall_obs);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stalls();
        test_bad_size();
        test_mid_reset();
        test_start_while_busy();
        test_random();
`ifdef DCT_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
